// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-requester block memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  function automatic int block_words(input int block_size);
    return 1 << block_size;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational two-way round-robin pick between the I and D requesters.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t winner
);

  always_comb begin
    grant_valid = i_req | d_req;
    if (i_req && d_req) winner = (last_owner == OWN_D) ? OWN_I : OWN_D;
    else if (i_req)     winner = OWN_I;
    else                winner = OWN_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported block memory between I refill and D load/store.
// Optional ARB_PERF_EN adds grant and wait-cycle counters on the perf_* ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 3,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        i_req,
  input  logic [ADDRESS_WIDTH-1:0]                    i_addr,
  output logic                                        i_gnt,
  output logic                                        i_done,
  input  logic                                        d_req,
  input  logic                                        d_we,
  input  logic [ADDRESS_WIDTH-1:0]                    d_addr,
  input  logic [DATA_WIDTH-1:0]                       d_wdata,
  output logic                                        d_gnt,
  output logic                                        d_done,
  output logic [block_words(BLOCK_SIZE)*DATA_WIDTH-1:0] rdata,
  output logic [ADDRESS_WIDTH-1:0]                    mem_address,
  output logic [DATA_WIDTH-1:0]                       mem_write_data,
  output logic                                        mem_write_enable,
  input  logic [block_words(BLOCK_SIZE)*DATA_WIDTH-1:0] mem_read_data,
  output logic [31:0]                                 perf_i_grants,
  output logic [31:0]                                 perf_d_grants,
  output logic [31:0]                                 perf_wait_cycles,
  output state_t                                      dbg_state
);

  state_t     state;
  owner_t     owner;
  logic       we_q;
  logic [3:0] cnt;
  logic       grant_valid;
  owner_t     winner;

  mem_arb_rr u_rr (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (owner),
    .grant_valid(grant_valid),
    .winner     (winner)
  );

  // Grants answer in the request cycle; everything else decodes registered state,
  // so write enable falls with the asynchronous reset of state.
  assign i_gnt            = (state == IDLE) && grant_valid && (winner == OWN_I);
  assign d_gnt            = (state == IDLE) && grant_valid && (winner == OWN_D);
  assign i_done           = (state == DONE) && (owner == OWN_I);
  assign d_done           = (state == DONE) && (owner == OWN_D);
  assign mem_write_enable = (state == BUSY) && (cnt == 4'd0) && we_q;
  assign dbg_state        = state;

  // owner doubles as last_owner: it keeps the most recent winner until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= OWN_D;
      we_q           <= 1'b0;
      cnt            <= 4'd0;
      mem_address    <= '0;
      mem_write_data <= '0;
      rdata          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner          <= winner;
            mem_address    <= (winner == OWN_I) ? i_addr : d_addr;
            mem_write_data <= (winner == OWN_D) ? d_wdata : '0;
            we_q           <= (winner == OWN_D) && d_we;
            cnt            <= 4'(MEM_LATENCY - 1);
            state          <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (!we_q) rdata <= mem_read_data;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants    <= '0;
      perf_d_grants    <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (i_gnt && (perf_i_grants != '1)) perf_i_grants <= perf_i_grants + 32'd1;
      if (d_gnt && (perf_d_grants != '1)) perf_d_grants <= perf_d_grants + 32'd1;
      if ((i_req || d_req) && !(i_gnt || d_gnt) && (perf_wait_cycles != '1))
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`else
  assign perf_i_grants    = '0;
  assign perf_d_grants    = '0;
  assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table, contention, perf and mid-write reset.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 30;
  localparam int BS = 3;
  localparam int L  = 2;
  localparam int S  = 8;

  logic            clk;
  logic            rst_n;
  logic            i_req, i_gnt, i_done;
  logic [AW-1:0]   i_addr;
  logic            d_req, d_we, d_gnt, d_done;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [S*DW-1:0] rdata;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_write_enable;
  logic [S*DW-1:0] mem_read_data;
  logic [31:0]     perf_i_grants, perf_d_grants, perf_wait_cycles;
  state_t          dbg_state;

  int n_checks;
  int n_errors;

  logic [DW-1:0]   mem_model [256];
  logic [DW-1:0]   ref_mem   [256];
  logic [S*DW-1:0] exp_rdata;

  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_idx;
    logic [DW-1:0] exp_word;
  } vec_t;

  vec_t vecs[7];

  mem_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS), .MEM_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done),
    .rdata(rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_wait_cycles(perf_wait_cycles),
    .dbg_state(dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write_enable) mem_model[mem_address[7:0]] = mem_write_data;
  end

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < S; i++)
      mem_read_data[i*DW +: DW] = mem_model[{mem_address[7:3], 3'(i)}];
  end

  task automatic chk(input string nm, input logic [S*DW-1:0] act, input logic [S*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [S*DW-1:0] block_of(input logic [AW-1:0] a);
    logic [S*DW-1:0] b;
    for (int i = 0; i < S; i++) b[i*DW +: DW] = ref_mem[{a[7:3], 3'(i)}];
    return b;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // driver: one transaction from IDLE, entered and left at posedge+1
  task automatic run_txn(input vec_t v);
    int cyc;
    int we_cnt;
    logic seen_done;
    if (!v.we) exp_rdata = block_of(v.addr);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    #1;
    chk("gnt_pair", {i_gnt, d_gnt}, v.is_d ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = AW'($urandom); d_addr = AW'($urandom); d_wdata = $urandom;
    cyc = 1; we_cnt = 0; seen_done = 1'b0;
    chk("busy_addr", mem_address, v.addr);
    while (cyc < 20) begin
      if (mem_write_enable) begin
        we_cnt++;
        chk("we_addr", mem_address, v.addr);
        chk("we_data", mem_write_data, v.wdata);
      end
      if (i_done || d_done) begin
        seen_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", seen_done, 1'b1);
    chk("done_latency", cyc, L + 1);
    chk("done_pair", {i_done, d_done}, v.is_d ? 2'b01 : 2'b10);
    chk("we_pulses", we_cnt, v.we ? 1 : 0);
    chk("rdata_block", rdata, exp_rdata);
    chk("rdata_word", rdata[v.exp_idx*DW +: DW], v.exp_word);
    if (v.we) ref_mem[v.addr[7:0]] = v.wdata;
    @(posedge clk); #1;
    chk("done_pulse", {i_done, d_done}, 2'b00);
    chk("back_idle", dbg_state, IDLE);
  endtask

  initial begin
    int ng, cyc, last_gnt, dones;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int a = 0; a < 256; a++) begin
      mem_model[a] = 32'hA000_0000 | 32'(a);
      ref_mem[a]   = 32'hA000_0000 | 32'(a);
    end
    exp_rdata = '0;

    vecs[0] = '{1'b0, 1'b0, 30'h10, 32'h0,         0, 32'hA000_0010};
    vecs[1] = '{1'b1, 1'b1, 30'h23, 32'hDEAD_BEEF, 7, 32'hA000_0017};
    vecs[2] = '{1'b1, 1'b0, 30'h20, 32'h0,         3, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 30'h40, 32'h0,         5, 32'hA000_0045};
    vecs[4] = '{1'b1, 1'b1, 30'h50, 32'h1234_5678, 5, 32'hA000_0045};
    vecs[5] = '{1'b1, 1'b0, 30'h57, 32'h0,         0, 32'h1234_5678};
    vecs[6] = '{1'b0, 1'b0, 30'h08, 32'h0,         0, 32'hA000_0008};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, IDLE);
    chk("rst_gnt_done", {i_gnt, d_gnt, i_done, d_done}, 4'b0000);
    chk("rst_rdata", rdata, '0);
    chk("rst_addr", mem_address, '0);
    chk("rst_wdata", mem_write_data, '0);
    chk("rst_we", mem_write_enable, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) run_txn(vecs[k]);

    // contention: both held, alternating from I after reset
    pulse_reset();
    i_addr = 30'h10; d_addr = 30'h18; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    #1;
    ng = 0; cyc = 0; last_gnt = 0; dones = 0;
    while (ng < 5 && cyc < 100) begin
      if (i_done || d_done) dones++;
      if (i_gnt || d_gnt) begin
        chk("alt_gnt", {i_gnt, d_gnt}, (ng % 2 == 0) ? 2'b10 : 2'b01);
        if (ng > 0) begin
          chk("gnt_spacing", cyc - last_gnt, L + 2);
          chk("done_before_gnt", dones, 1);
        end
        dones = 0; last_gnt = cyc; ng++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("contention_grants", ng, 5);
    repeat (L + 2) @(posedge clk);
    #1;
    chk("contention_idle", dbg_state, IDLE);
`ifdef ARB_PERF_EN
    chk("perf_i", perf_i_grants, 3);
    chk("perf_d", perf_d_grants, 2);
    chk("perf_wait", perf_wait_cycles, 4 * (L + 1));
`else
    chk("perf_i_tied", perf_i_grants, 0);
    chk("perf_d_tied", perf_d_grants, 0);
    chk("perf_wait_tied", perf_wait_cycles, 0);
`endif

    // reset in the final busy cycle of a write
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h08; d_wdata = 32'hCAFE_F00D;
    #1;
    chk("abort_gnt", d_gnt, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    repeat (L - 1) @(posedge clk);
    #1;
    chk("abort_we_armed", mem_write_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_async", mem_write_enable, 1'b0);
    chk("abort_rdata", rdata, '0);
    chk("abort_state", dbg_state, IDLE);
    @(negedge clk); #2;
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (d_done || i_done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_idle", dbg_state, IDLE);
    chk("abort_mem_kept", mem_model[8], 32'hA000_0008);
    run_txn(vecs[6]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
